axi_slave_ram: RTL and testbench
================================

// Module: axi_slave_ram
// PURPOSE
//  AXI4 slave (responder) backed by a word-addressed RAM array; the target end of the core's m_axi master.
//  Serves i/d-cache line fills (INCR read bursts) and write-backs (INCR write bursts) in simulation and FPGA.
//  Independent read and write engines run concurrently; the array has 1 combinational read port, 1 write port.
// PARAMETERS
//  MEM_WORDS  4096          depth in 32-bit words (power of 2)
//  BASE_ADDR  32'h0000_0000 byte address of word 0; in range = BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS
// PORTS
//  aclk           in   1   single clock, all logic rising-edge
//  areset         in   1   asynchronous, active-high reset
//  s_axi_awid     in   4   write ID
//  s_axi_awaddr   in   32  write burst start byte address
//  s_axi_awlen    in   8   beats-1
//  s_axi_awsize   in   3   must be 3'b010
//  s_axi_awburst  in   2   00 FIXED, 01 INCR, 10 WRAP (unsupported)
//  s_axi_awvalid  in   1   / s_axi_awready out 1
//  s_axi_wdata    in   32  / s_axi_wstrb in 4 / s_axi_wlast in 1 / s_axi_wvalid in 1 / s_axi_wready out 1
//  s_axi_bid      out  4   / s_axi_bresp out 2 / s_axi_bvalid out 1 / s_axi_bready in 1
//  s_axi_arid     in   4   / s_axi_araddr in 32 / s_axi_arlen in 8 / s_axi_arsize in 3 / s_axi_arburst in 2
//  s_axi_arvalid  in   1   / s_axi_arready out 1
//  s_axi_rid      out  4   / s_axi_rdata out 32 / s_axi_rresp out 2 / s_axi_rlast out 1
//  s_axi_rvalid   out  1   / s_axi_rready in 1
// BEHAVIOUR
//  Reset (areset=1, any time): both FSMs -> IDLE; all ready/valid outputs 0; rdata/rid/bid/rresp/bresp 0.
//   RAM contents are NOT reset. Reset mid-burst abandons the burst silently (no B, no further R).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: awready=1. AW handshake at cycle N latches id/addr/len/burst, beat cnt=0, err flag set if
//    awsize!=010 or awburst==WRAP; wready=1 from N+1.
//   W_DATA: wready=1. Each W handshake writes byte lanes with wstrb=1 to word (addr-BASE_ADDR)>>2;
//    out-of-range beat: write dropped, err set. INCR: addr+=4 after beat; FIXED: addr unchanged.
//    err set if wlast !== (cnt==len). Burst ends on beat cnt==len (wlast ignored for termination).
//   W_RESP: bvalid=1 from cycle after final beat, bid=latched awid, bresp=err?2'b10(SLVERR):2'b00;
//    held stable until bready; on B handshake -> W_IDLE (awready=1 next cycle).
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: arready=1. AR handshake at cycle N latches id/addr/len/burst; rvalid=1 at N+1 with beat 0.
//   R_DATA: rdata = mem[word index] (0 if out of range), rresp=SLVERR if out of range, bad size or WRAP,
//    else OKAY; rlast=(cnt==len); rid=latched arid. All R outputs stable while rvalid && !rready.
//    Each R handshake advances addr (INCR +4, FIXED hold) and cnt; next beat presented next cycle,
//    rvalid stays 1 (full throughput: len+1 beats in len+1 cycles with rready=1).
//   R handshake with rlast -> R_IDLE, rvalid=0 and arready=1 next cycle.
//  Address arithmetic: 32-bit, wraps modulo 2^32; 4K-boundary crossing not checked.
//  Same-cycle R beat and W beat to same word: R returns old data, write visible from next cycle.
//  No outstanding transactions: single AR and single AW in flight; no ID reordering.
//  awready/arready deassert the cycle after their handshake; never depend on valid combinationally.
// TESTING
//  1 Reset: hold areset 3 cycles, release -> awready=arready=1, all valids 0; assert areset mid read burst -> rvalid=0 same cycle.
//  2 Preload words 0..7 = 32'hA0+i; AR addr=BASE_ADDR,len=7,INCR, rready toggling 1/0 -> 8 beats 0xA0..0xA7, rlast only on 8th, rid=arid, OKAY.
//  3 AW addr=BASE_ADDR+0x20,len=3,id=5; W data 0x11111111*k, wstrb=4'b0101 on beat 1 -> B id=5 OKAY; read back shows only bytes 0,2 changed on word 9.
//  4 AR addr=BASE_ADDR+4*MEM_WORDS, len=1 -> 2 beats rdata=0 rresp=2'b10; AW same addr -> RAM unchanged, bresp=2'b10.
//  5 Write len=3 with wlast on beat 2 -> 4 beats accepted, bresp=SLVERR; awsize=3'b001 -> SLVERR; FIXED len=3 to word 4 -> word 4 holds last beat.
//  6 Concurrent 8-beat read and 8-beat write overlapping word 2 with bready held 0 for 5 cycles -> read old data, bvalid held stable, both complete.

Source files
------------

// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : axi_slave_ram
// Description : AXI4 slave backed by a word-addressed RAM array. Independent
//               read and write engines run concurrently and serve INCR/FIXED
//               bursts of 32-bit beats. The array has one combinational read
//               port and one byte-enabled write port.
// Ports       : aclk, areset        - clock, asynchronous active-high reset
//               s_axi_aw*           - write address channel
//               s_axi_w*            - write data channel
//               s_axi_b*            - write response channel
//               s_axi_ar*           - read address channel
//               s_axi_r*            - read data channel
// Revision    : 1.0 - initial release
// ============================================================================
module axi_slave_ram #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  s_axi_awid,
    input  logic [31:0] s_axi_awaddr,
    input  logic [7:0]  s_axi_awlen,
    input  logic [2:0]  s_axi_awsize,
    input  logic [1:0]  s_axi_awburst,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wlast,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [3:0]  s_axi_bid,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [3:0]  s_axi_arid,
    input  logic [31:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [3:0]  s_axi_rid,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int          c_IDX_W       = $clog2(MEM_WORDS);
    // 33 bits so the byte span never overflows the comparison
    localparam logic [32:0] c_MEM_BYTES   = 33'(MEM_WORDS) << 2;
    localparam logic [1:0]  c_BURST_FIXED = 2'b00;
    localparam logic [1:0]  c_BURST_WRAP  = 2'b10;
    localparam logic [2:0]  c_SIZE_WORD   = 3'b010;
    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;

    localparam logic [1:0]  c_W_IDLE = 2'd0;
    localparam logic [1:0]  c_W_DATA = 2'd1;
    localparam logic [1:0]  c_W_RESP = 2'd2;
    localparam logic [0:0]  c_R_IDLE = 1'b0;
    localparam logic [0:0]  c_R_DATA = 1'b1;

    logic [31:0] r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    logic [1:0]         r_wstate, w_wstate_nxt;
    logic               r_awready, r_wready, r_bvalid;
    logic [3:0]         r_awid;
    logic [31:0]        r_awaddr;
    logic [7:0]         r_awlen, r_wcnt;
    logic [1:0]         r_awburst;
    logic               r_werr;
    logic               w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_win_range;
    logic [31:0]        w_woff;
    logic [c_IDX_W-1:0] w_widx;

    assign w_aw_hs      = r_awready & s_axi_awvalid;
    assign w_w_hs       = r_wready & s_axi_wvalid;
    assign w_b_hs       = r_bvalid & s_axi_bready;
    // Burst length alone terminates the burst; wlast only feeds the error flag
    assign w_wlast_beat = (r_wcnt == r_awlen);
    assign w_woff       = r_awaddr - BASE_ADDR;
    assign w_win_range  = ({1'b0, w_woff} < c_MEM_BYTES);
    assign w_widx       = w_woff[c_IDX_W+1:2];

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            c_W_IDLE: if (w_aw_hs) w_wstate_nxt = c_W_DATA;
            c_W_DATA: if (w_w_hs && w_wlast_beat) w_wstate_nxt = c_W_RESP;
            c_W_RESP: if (w_b_hs) w_wstate_nxt = c_W_IDLE;
            default:  w_wstate_nxt = c_W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= c_W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            // Handshake flags are registered from the next state so they
            // never depend combinationally on the valid inputs
            r_awready <= (w_wstate_nxt == c_W_IDLE);
            r_wready  <= (w_wstate_nxt == c_W_DATA);
            r_bvalid  <= (w_wstate_nxt == c_W_RESP);
            if (w_aw_hs) begin
                r_awid    <= s_axi_awid;
                r_awaddr  <= s_axi_awaddr;
                r_awlen   <= s_axi_awlen;
                r_awburst <= s_axi_awburst;
                r_wcnt    <= '0;
                r_werr    <= (s_axi_awsize != c_SIZE_WORD) || (s_axi_awburst == c_BURST_WRAP);
            end
            if (w_w_hs) begin
                r_wcnt <= r_wcnt + 8'd1;
                if (r_awburst != c_BURST_FIXED) begin
                    r_awaddr <= r_awaddr + 32'd4;
                end
                if (!w_win_range || (s_axi_wlast != w_wlast_beat)) begin
                    r_werr <= 1'b1;
                end
            end
        end
    end

    // RAM contents are deliberately left out of reset
    always_ff @(posedge aclk) begin
        if (w_w_hs && w_win_range) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_awid;
    assign s_axi_bresp   = (r_bvalid && r_werr) ? c_RESP_SLVERR : c_RESP_OKAY;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    logic [0:0]         r_rstate, w_rstate_nxt;
    logic               r_arready, r_rvalid;
    logic [3:0]         r_arid;
    logic [31:0]        r_araddr;
    logic [7:0]         r_arlen, r_rcnt;
    logic [1:0]         r_arburst;
    logic               r_rbad;
    logic               w_ar_hs, w_r_hs, w_rlast_beat, w_rin_range;
    logic [31:0]        w_roff;
    logic [c_IDX_W-1:0] w_ridx;

    assign w_ar_hs      = r_arready & s_axi_arvalid;
    assign w_r_hs       = r_rvalid & s_axi_rready;
    assign w_rlast_beat = (r_rcnt == r_arlen);
    assign w_roff       = r_araddr - BASE_ADDR;
    assign w_rin_range  = ({1'b0, w_roff} < c_MEM_BYTES);
    assign w_ridx       = w_roff[c_IDX_W+1:2];

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs) w_rstate_nxt = c_R_DATA;
            c_R_DATA: if (w_r_hs && w_rlast_beat) w_rstate_nxt = c_R_IDLE;
            default:  w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= c_R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
            r_rbad    <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == c_R_IDLE);
            r_rvalid  <= (w_rstate_nxt == c_R_DATA);
            if (w_ar_hs) begin
                r_arid    <= s_axi_arid;
                r_araddr  <= s_axi_araddr;
                r_arlen   <= s_axi_arlen;
                r_arburst <= s_axi_arburst;
                r_rcnt    <= '0;
                r_rbad    <= (s_axi_arsize != c_SIZE_WORD) || (s_axi_arburst == c_BURST_WRAP);
            end
            if (w_r_hs) begin
                r_rcnt <= r_rcnt + 8'd1;
                if (r_arburst != c_BURST_FIXED) begin
                    r_araddr <= r_araddr + 32'd4;
                end
            end
        end
    end

    // Combinational read: a same-cycle write to this word lands at the edge,
    // so the beat presented now carries the old contents
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_arid;
    assign s_axi_rdata   = (r_rvalid && w_rin_range) ? r_mem[w_ridx] : 32'd0;
    assign s_axi_rresp   = (r_rvalid && (!w_rin_range || r_rbad)) ? c_RESP_SLVERR : c_RESP_OKAY;
    assign s_axi_rlast   = r_rvalid && w_rlast_beat;

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_slave_ram
// Description : Self-checking bench for axi_slave_ram. Directed scenarios plus
//               randomized bursts, compared against a word-array model of the
//               RAM updated from the AXI rules (range check, byte strobes,
//               INCR/FIXED addressing, error accumulation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_slave_ram;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h2000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_arid;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_rid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    always #5 aclk = ~aclk;

    axi_slave_ram #(.MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)) dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [MEM_WORDS];
    bit          known [MEM_WORDS];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a - BASE_ADDR) < 32'(4 * MEM_WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE_ADDR) >> 2);
    endfunction

    // Write burst using wd/ws as beat data; wlast is driven on beat wlast_at.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size,
                             input int wlast_at, input int bready_hold);
        logic [31:0] a;
        bit          err;
        logic [1:0]  exp_resp;
        int          i;
        a   = addr;
        err = (size != 3'b010) || (burst == 2'b10);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        for (int n = 0; n < 20 && s_axi_awready !== 1'b1; n++) tick();
        check("awready", 32'(s_axi_awready), 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            s_axi_wdata = wd[k]; s_axi_wstrb = ws[k];
            s_axi_wlast = (k == wlast_at); s_axi_wvalid = 1'b1;
            for (int n = 0; n < 20 && s_axi_wready !== 1'b1; n++) tick();
            check("wready", 32'(s_axi_wready), 32'd1);
            tick();
            // The beat was committed at the edge just passed
            if (in_range(a)) begin
                i = widx(a);
                for (int b = 0; b < 4; b++)
                    if (ws[k][b]) model[i][8*b +: 8] = wd[k][8*b +: 8];
                if (ws[k] == 4'hF) known[i] = 1'b1;
            end else begin
                err = 1'b1;
            end
            if ((k == wlast_at) != (k == len)) err = 1'b1;
            if (burst != 2'b00) a = a + 32'd4;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        s_axi_bready = 1'b0;
        check("bvalid", 32'(s_axi_bvalid), 32'd1);
        for (int n = 0; n < bready_hold; n++) begin
            tick();
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            check("bid_hold", 32'(s_axi_bid), 32'(id));
            check("bresp_hold", 32'(s_axi_bresp), 32'(exp_resp));
        end
        s_axi_bready = 1'b1;
        check("bid", 32'(s_axi_bid), 32'(id));
        check("bresp", 32'(s_axi_bresp), 32'(exp_resp));
        tick();
        s_axi_bready = 1'b0;
        check("bvalid_clr", 32'(s_axi_bvalid), 32'd0);
        check("awready_back", 32'(s_axi_awready), 32'd1);
    endtask

    // Read burst; mode 0: rready held 1, 1: toggling 1/0, 2: random.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input logic [2:0] size, input int mode);
        logic [31:0] a;
        bit          bad;
        int          k, cyc;
        a = addr; k = 0; cyc = 0;
        bad = (size != 3'b010) || (burst == 2'b10);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && s_axi_arready !== 1'b1; n++) tick();
        check("arready", 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        while (k <= len && cyc < 200) begin
            if (mode == 0)      s_axi_rready = 1'b1;
            else if (mode == 1) s_axi_rready = (cyc % 2 == 0);
            else                s_axi_rready = 1'($urandom_range(0, 1));
            #4;
            check("rvalid", 32'(s_axi_rvalid), 32'd1);
            if (!in_range(a))          check("rdata_oor", s_axi_rdata, 32'd0);
            else if (known[widx(a)])   check("rdata", s_axi_rdata, model[widx(a)]);
            check("rresp", 32'(s_axi_rresp), (!in_range(a) || bad) ? 32'd2 : 32'd0);
            check("rlast", 32'(s_axi_rlast), 32'(k == len));
            check("rid", 32'(s_axi_rid), 32'(id));
            @(posedge aclk);
            #1;
            if (s_axi_rready) begin
                k++;
                if (burst != 2'b00) a = a + 32'd4;
            end
            cyc++;
        end
        s_axi_rready = 1'b0;
        check("rvalid_end", 32'(s_axi_rvalid), 32'd0);
        check("arready_back", 32'(s_axi_arready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base;
        int          len;
        areset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b010;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) begin model[i] = '0; known[i] = 1'b0; end

        // Reset behaviour
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        areset = 1'b0;
        tick();
        check("post_awready", 32'(s_axi_awready), 32'd1);
        check("post_arready", 32'(s_axi_arready), 32'd1);
        check("post_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("post_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("post_wready", 32'(s_axi_wready), 32'd0);
        check("post_bresp", 32'(s_axi_bresp), 32'd0);

        // Preload words 0..15 (0..7 = 0xA0+i), then toggled-rready read of 0..7
        for (int i = 0; i < 16; i++) begin
            wd[i] = (i < 8) ? 32'hA0 + 32'(i) : $urandom;
            ws[i] = 4'hF;
        end
        axi_write(4'd1, BASE_ADDR, 15, 2'b01, 3'b010, 15, 0);
        axi_read(4'd3, BASE_ADDR, 7, 2'b01, 3'b010, 1);

        // Partial strobe on word 9
        for (int k = 0; k < 4; k++) begin
            wd[k] = 32'h11111111 * 32'(k + 1);
            ws[k] = (k == 1) ? 4'b0101 : 4'hF;
        end
        axi_write(4'd5, BASE_ADDR + 32'h20, 3, 2'b01, 3'b010, 3, 0);
        axi_read(4'd6, BASE_ADDR + 32'h20, 3, 2'b01, 3'b010, 0);

        // Out-of-range read and write
        axi_read(4'd7, BASE_ADDR + 32'(4 * MEM_WORDS), 1, 2'b01, 3'b010, 0);
        wd[0] = $urandom; wd[1] = $urandom; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(4'd8, BASE_ADDR + 32'(4 * MEM_WORDS), 1, 2'b01, 3'b010, 1, 0);
        axi_read(4'd9, BASE_ADDR, 15, 2'b01, 3'b010, 2);

        // Early wlast, bad size, FIXED burst
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        axi_write(4'd2, BASE_ADDR + 32'd80, 3, 2'b01, 3'b010, 2, 0);
        axi_read(4'd2, BASE_ADDR + 32'd80, 3, 2'b01, 3'b010, 0);
        wd[0] = $urandom; ws[0] = 4'hF;
        axi_write(4'd4, BASE_ADDR + 32'd120, 0, 2'b01, 3'b001, 0, 0);
        for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        axi_write(4'd3, BASE_ADDR + 32'd16, 3, 2'b00, 3'b010, 3, 0);
        axi_read(4'd1, BASE_ADDR + 32'd16, 0, 2'b01, 3'b010, 0);
        check("fixed_word4", model[4], wd[3]);
        axi_read(4'd1, BASE_ADDR, 0, 2'b10, 3'b010, 0);

        // Concurrent read from word 2 and write from word 0, bready held off
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
        fork
            axi_write(4'hA, BASE_ADDR, 7, 2'b01, 3'b010, 7, 5);
            axi_read(4'hB, BASE_ADDR + 32'd8, 7, 2'b01, 3'b010, 0);
        join
        axi_read(4'hC, BASE_ADDR, 9, 2'b01, 3'b010, 2);

        // Randomized bursts
        for (int t = 0; t < 6; t++) begin
            base = BASE_ADDR + 32'(4 * $urandom_range(64, 200));
            len  = $urandom_range(0, 7);
            for (int k = 0; k < 8; k++) begin
                wd[k] = $urandom;
                ws[k] = (k == 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            axi_write(4'($urandom_range(0, 15)), base, len, 2'b01, 3'b010, len, $urandom_range(0, 3));
            axi_read(4'($urandom_range(0, 15)), base, len, 2'b01, 3'b010, 2);
        end

        // Reset in the middle of a read burst
        s_axi_arid = 4'd9; s_axi_araddr = BASE_ADDR; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'b010; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && s_axi_arready !== 1'b1; n++) tick();
        tick();
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        check("mid_rvalid", 32'(s_axi_rvalid), 32'd1);
        #2 areset = 1'b1;
        #1;
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("mid_rst_rdata", s_axi_rdata, 32'd0);
        check("mid_rst_arready", 32'(s_axi_arready), 32'd0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        tick();
        check("rel_arready", 32'(s_axi_arready), 32'd1);
        check("rel_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rel_bvalid", 32'(s_axi_bvalid), 32'd0);
        axi_read(4'd4, BASE_ADDR, 3, 2'b01, 3'b010, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
